// File: rtl/cordic_sincos_gen.sv
// rtl/cordic_sincos_gen.sv - iterative CORDIC sine/cosine generator; optional phase sweep under CORDIC_SWEEP_EN
module cordic_sincos_gen #(
   parameter int OUT_W   = 8,
   parameter int ITER    = 12,
   parameter int ANGLE_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mode,
   input  logic [ANGLE_W-1:0]       angle,
   input  logic [ANGLE_W-1:0]       step,
   input  logic                     stop,
   output logic signed [OUT_W-1:0]  sin_o,
   output logic signed [OUT_W-1:0]  cos_o,
   output logic                     busy,
   output logic                     done,
   output logic                     wrap
);
   // x/y carry 3 fractional bits below the output LSB plus one guard bit
   localparam int XW  = OUT_W + 4;
   // z is in 0.01 degree with 4 fractional bits
   localparam int ZW  = ANGLE_W + 4;
   localparam int CW  = $clog2(ITER);
   localparam int AMP = (1 << (OUT_W - 1)) - 1;
   localparam longint AMP_L = longint'(AMP);
   // full-scale amplitude (AMP << 3) pre-multiplied by K = 0.60725, rounded
   localparam longint X0_L  = (AMP_L * 8 * 60725 + 50000) / 100000;

   localparam logic [ANGLE_W-1:0] P90  = ANGLE_W'(9000);
   localparam logic [ANGLE_W-1:0] P180 = ANGLE_W'(18000);
   localparam logic [ANGLE_W-1:0] P270 = ANGLE_W'(27000);
   localparam logic [ANGLE_W-1:0] P360 = ANGLE_W'(36000);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_OUT} state_t;

   // atan(2^-i) in 0.01 degree units scaled by 16
   function automatic logic signed [ZW-1:0] atan_c(input logic [3:0] i);
      logic signed [ZW-1:0] r;
      r = '0;
      case (i)
         4'd0:  r = ZW'(72000);
         4'd1:  r = ZW'(42504);
         4'd2:  r = ZW'(22458);
         4'd3:  r = ZW'(11400);
         4'd4:  r = ZW'(5722);
         4'd5:  r = ZW'(2864);
         4'd6:  r = ZW'(1432);
         4'd7:  r = ZW'(716);
         4'd8:  r = ZW'(358);
         4'd9:  r = ZW'(179);
         4'd10: r = ZW'(90);
         4'd11: r = ZW'(45);
         4'd12: r = ZW'(22);
         4'd13: r = ZW'(11);
         4'd14: r = ZW'(6);
         default: r = ZW'(3);
      endcase
      return r;
   endfunction

   // drop the 3 fractional bits with round-half-up, clamp to +/-AMP, then apply quadrant sign
   function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [XW-1:0] v, input logic neg);
      logic signed [XW:0]      ve;
      logic signed [XW:0]      r;
      logic signed [OUT_W-1:0] m;
      ve = (XW+1)'(v);
      r  = (ve + (XW+1)'(4)) >>> 3;
      if (r > AMP) begin
         m = OUT_W'(AMP);
      end else if (r < -AMP) begin
         m = OUT_W'(-AMP);
      end else begin
         m = OUT_W'(r);
      end
      if (neg) begin
         m = -m;
      end
      return m;
   endfunction

   state_t                  state_q;
   logic [ANGLE_W-1:0]      phase_q;
   logic [CW-1:0]           iter_q;
   logic signed [XW-1:0]    x_q, y_q;
   logic signed [ZW-1:0]    z_q;
   logic                    sin_neg_q, cos_neg_q, wrap_flag_q;
   logic signed [OUT_W-1:0] sin_q, cos_q;
   logic                    busy_q, done_q, wrap_q;

   logic                    wrap_d, sneg_d, cneg_d;
   logic [ANGLE_W-1:0]      red_d, fold_d;
   logic signed [XW-1:0]    x_sh, y_sh, x_d, y_d;
   logic signed [ZW-1:0]    z_d;

`ifdef CORDIC_SWEEP_EN
   logic                    mode_q, stop_q;
   logic [ANGLE_W-1:0]      step_q;
   logic [ANGLE_W:0]        sum_d;
   logic [ANGLE_W-1:0]      next_phase_d;

   // next sweep phase: one conditional subtract keeps it below 36000 for reduced phase + step
   always_comb begin
      sum_d = {1'b0, phase_q} + {1'b0, step_q};
      next_phase_d = sum_d[ANGLE_W-1:0];
      if (sum_d >= (ANGLE_W+1)'(36000)) begin
         next_phase_d = ANGLE_W'(sum_d - (ANGLE_W+1)'(36000));
      end
   end
`else
   logic unused_sweep_ports;
   assign unused_sweep_ports = ^{mode, step, stop};
`endif

   // reduce the phase once by 36000 and fold it into 0..9000 with sign flags
   always_comb begin
      wrap_d = (phase_q >= P360);
      red_d  = wrap_d ? (phase_q - P360) : phase_q;
      fold_d = red_d;
      sneg_d = 1'b0;
      cneg_d = 1'b0;
      if (red_d <= P90) begin
         fold_d = red_d;
      end else if (red_d <= P180) begin
         fold_d = P180 - red_d;
         cneg_d = 1'b1;
      end else if (red_d <= P270) begin
         fold_d = red_d - P180;
         sneg_d = 1'b1;
         cneg_d = 1'b1;
      end else begin
         fold_d = P360 - red_d;
         sneg_d = 1'b1;
      end
   end

   // one micro-rotation, direction chosen by the sign of the residual angle
   always_comb begin
      x_sh = x_q >>> iter_q;
      y_sh = y_q >>> iter_q;
      if (!z_q[ZW-1]) begin
         x_d = x_q - y_sh;
         y_d = y_q + x_sh;
         z_d = z_q - atan_c(4'(iter_q));
      end else begin
         x_d = x_q + y_sh;
         y_d = y_q - x_sh;
         z_d = z_q + atan_c(4'(iter_q));
      end
   end

   // control FSM and all registered state/outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         iter_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         sin_neg_q   <= 1'b0;
         cos_neg_q   <= 1'b0;
         wrap_flag_q <= 1'b0;
         sin_q       <= '0;
         cos_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
`ifdef CORDIC_SWEEP_EN
         mode_q      <= 1'b0;
         stop_q      <= 1'b0;
         step_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         wrap_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  phase_q <= angle;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
`ifdef CORDIC_SWEEP_EN
                  mode_q  <= mode;
                  step_q  <= step;
                  stop_q  <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
               phase_q     <= red_d;
               wrap_flag_q <= wrap_d;
               sin_neg_q   <= sneg_d;
               cos_neg_q   <= cneg_d;
               x_q         <= XW'(X0_L);
               y_q         <= '0;
               z_q         <= $signed({fold_d, 4'b0000});
               iter_q      <= '0;
               state_q     <= S_ROT;
`ifdef CORDIC_SWEEP_EN
               if (stop) stop_q <= 1'b1;
`endif
            end
            S_ROT: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (iter_q == CW'(ITER - 1)) begin
                  state_q <= S_OUT;
               end else begin
                  iter_q <= iter_q + CW'(1);
               end
`ifdef CORDIC_SWEEP_EN
               if (stop) stop_q <= 1'b1;
`endif
            end
            S_OUT: begin
               sin_q  <= scale_out(y_q, sin_neg_q);
               cos_q  <= scale_out(x_q, cos_neg_q);
               done_q <= 1'b1;
               wrap_q <= wrap_flag_q;
`ifdef CORDIC_SWEEP_EN
               if (mode_q && !stop_q && !stop) begin
                  phase_q <= next_phase_d;
                  state_q <= S_LOAD;
               end else begin
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
`else
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
`endif
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign sin_o = sin_q;
   assign cos_o = cos_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign wrap  = wrap_q;
endmodule

// File: doc/cordic_sincos_gen.md
CORDIC_SINCOS_GEN -- requirements
Module: cordic_sincos_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- OUT_W, 8, sin/cos output width in bits, signed, range 6..16.
- ITER, 12, number of CORDIC micro-rotations, range 8..16.
- ANGLE_W, 16, angle/step width; unit is 0.01 degree.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, reset, asynchronous and active-high.
- start, in, 1, request; sampled only in IDLE.
- mode, in, 1, operation mode: 0 = single-shot, 1 = sweep; sampled with start.
- angle, in, ANGLE_W, start phase; sampled with start.
- step, in, ANGLE_W, sweep phase increment; sampled with start.
- stop, in, 1, ends sweep after the current result.
- sin_o, out, OUT_W, signed sine result, registered.
- cos_o, out, OUT_W, signed cosine result, registered.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when sin_o/cos_o update.
- wrap, out, 1, qualified by done; high if the phase for that result was ≥36000 before reduction.

Function
REQ-003 FSM states: IDLE, LOAD, ROT, OUT.
- IDLE -> LOAD when start=1.
- LOAD -> ROT after 1 cycle.
- ROT -> OUT after ITER cycles.
- OUT -> IDLE (single-shot, or stop seen) or LOAD (sweep).
REQ-004 Latency: start sampled at edge N gives done=1 at edge N+ITER+2, with sin_o/cos_o valid in the same cycle.
REQ-005 Results hold until the next done; done is never high two consecutive cycles.
REQ-006 start while busy=1 is ignored; angle, step and mode are not re-sampled.
REQ-007 LOAD phase reduction:
- Phase ≥36000 is reduced by one subtraction of 36000; this also covers the 65535 maximum.
- Reduced phase is folded to the first quadrant, with sign flags for sin and cos.
REQ-008 ROT datapath:
- x/y width OUT_W+4; z width ANGLE_W+4, with 4 fractional bits.
- Arctangent constants in the same unit, fixed for i = 0..15.
- x starts pre-scaled by the CORDIC gain K = 0.60725.
REQ-009 OUT scaling:
- Results are rounded to OUT_W bits and saturated to ±(2^(OUT_W-1)-1).
- The value -2^(OUT_W-1) is never produced.
- Accuracy is within ±1 LSB of round((2^(OUT_W-1)-1)·sin/cos).
REQ-010 Sweep mode:
- In OUT, phase ← (phase + step) mod 36000, using one conditional subtract of 36000 on the ANGLE_W+1-bit sum.
- Then go to LOAD; results are spaced ITER+2 cycles apart.
REQ-011 stop handling:
- stop is latched in any busy cycle.
- The sweep ends after the next done, then returns to IDLE.
- stop has no effect in IDLE or in single-shot mode.
REQ-012 step=0 in sweep mode repeats the same result until stop.

Reset
REQ-013 rst=1 immediately forces: state IDLE, sin_o=0, cos_o=0, busy=0, done=0, wrap=0, latched stop cleared.
REQ-014 rst during LOAD/ROT/OUT aborts the computation; no done is issued for it.
REQ-015 After rst deasserts, the first start is accepted normally.

Configuration
REQ-016 Macro CORDIC_SWEEP_EN.
- Defined: mode, step and stop are functional per REQ-010 to REQ-012.
- Undefined:
  - Ports remain, but mode, step and stop are ignored.
  - Every request is single-shot.
  - The phase accumulator and step adder are not synthesised.

Verification
REQ-017 Single-shot, OUT_W=8, ITER=12, one result per case, each within ±1 LSB:
- angle=4500 -> done at +14 cycles; sin_o=90, cos_o=90; wrap=0.
- angle=9000 -> sin_o=127, cos_o=0.
- angle=18000 -> sin_o=0, cos_o=-127.
- angle=27000 -> sin_o=-127, cos_o=0.
REQ-018 angle=36000 -> sin_o=0, cos_o=127, wrap=1.
- angle=45000 -> treated as 9000: sin_o=127, wrap=1.
REQ-019 Sweep: mode=1, angle=0, step=9000; stop raised after the 4th done.
- Expect 5 done pulses, each 14 cycles apart.
- cos_o sequence: 127, 0, -127, 0, 127.
- busy then falls.
REQ-020 Busy and reset behaviour:
- start pulsed again while busy=1 -> ignored; exactly one done.
- rst asserted at ROT cycle 5 -> outputs 0 at once, no done.
- Next start with angle=3000 -> sin_o=64, cos_o=110.
REQ-021 Macro undefined, mode=1, step=9000 -> single done, then IDLE.
